load_store_unit: RTL and testbench

//  Multi-cycle memory-access stage that sits directly downstream of the ALU.
//  It takes the effective address (ALU result), store data (rt read data) and
//  the read/write controls, and runs a req/ack transaction on a slower data

---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Data-memory port between the load/store unit and a slower memory.
//   The LSU drives the request side; memory answers with mem_ack/mem_rdata.
//   Ports:
//     mem_req    request, held until ack
//     mem_we     1 = write
//     mem_addr   word-aligned byte address
//     mem_wdata  lane-replicated store data
//     mem_wstrb  byte enables, little-endian
//     mem_ack    memory completes the request this cycle
//     mem_rdata  read word, valid with mem_ack
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle memory-access stage behind the ALU. Accepts a load or store
//   from execute, runs one req/ack transaction on the data-memory port while
//   stalling the core, and returns sign/zero-extended load data.
//   Optional feature macro: MISALIGN_TRAP_EN (trap misaligned half/word
//   accesses instead of silently ignoring the low address bits).
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     ex_valid/rd/wr    execute stage request (write wins when both set)
//     ex_addr/wdata     effective byte address, store data
//     ex_size/signed    00 byte, 01 half, 1x word; load extension select
//     stall             freeze PC/execute while high
//     ld_valid/ld_data  one-cycle load completion pulse, registered data
//     bus_err           one-cycle pulse: memory did not ack in time
//     misalign          one-cycle pulse: misaligned access trapped
//     mem               data-memory port (master side)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no access outstanding
//   REQ     | mem_req asserted, waiting for mem_ack or timeout
//   DONE    | one-cycle completion slot; a new access may start here
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_valid,
    input  logic                     ex_rd,
    input  logic                     ex_wr,
    input  logic [31:0]              ex_addr,
    input  logic [31:0]              ex_wdata,
    input  logic [1:0]               ex_size,
    input  logic                     ex_signed,
    output logic                     stall,
    output logic                     ld_valid,
    output logic [31:0]              ld_data,
    output logic                     bus_err,
    output logic                     misalign,
    load_store_unit_if.master        mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Timeout is a down-counter loaded with TIMEOUT-1 on entry to REQ;
    // reaching zero without ack is the terminal count.
    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    state_t      state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  lane_q, lane_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        ld_valid_q, ld_valid_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        bus_err_q, bus_err_d;
    logic        misalign_q, misalign_d;

    logic        start;
    logic        accept;
    logic        mis_trap;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_ext;

    assign start  = ex_valid & (ex_rd | ex_wr);
    assign accept = start & (state_q != ST_REQ);

`ifdef MISALIGN_TRAP_EN
    assign mis_trap = ((ex_size == 2'b01) & ex_addr[0]) |
                      (ex_size[1] & (ex_addr[1:0] != 2'b00));
`else
    assign mis_trap = 1'b0;
`endif

    // Byte enables and lane replication for the incoming access. Halves use
    // only a[1] and words only lane 0, so untrapped low bits are ignored.
    always_comb begin
        st_strb  = 4'b1111;
        st_wdata = ex_wdata;
        case (ex_size)
            2'b00: begin
                st_strb  = 4'b0001 << ex_addr[1:0];
                st_wdata = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                st_strb  = ex_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex_wdata[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = ex_wdata;
            end
        endcase
    end

    // Lane extraction of the returned word using the latched access shape.
    always_comb begin
        rd_byte = mem.mem_rdata[{lane_q, 3'b000} +: 8];
        rd_half = lane_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        ld_ext  = mem.mem_rdata;
        case (size_q)
            2'b00:   ld_ext = sgn_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            2'b01:   ld_ext = sgn_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        lane_d      = lane_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        ld_valid_d  = 1'b0;
        ld_data_d   = ld_data_q;
        bus_err_d   = 1'b0;
        misalign_d  = 1'b0;

        case (state_q)
            ST_REQ: begin
                // Ack on the terminal-count cycle still completes normally.
                if (mem.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                    if (!mem_we_q) begin
                        ld_valid_d = 1'b1;
                        ld_data_d  = ld_ext;
                    end
                end else if ((TIMEOUT != 0) && (tmr_q == '0)) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                    bus_err_d = 1'b1;
                    ld_data_d = 32'h0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // accept is never true in REQ, so this cannot collide with the above.
        if (accept) begin
            size_d      = ex_size;
            sgn_d       = ex_signed;
            lane_d      = ex_addr[1:0];
            mem_we_d    = ex_wr;
            mem_addr_d  = {ex_addr[31:2], 2'b00};
            mem_wdata_d = st_wdata;
            mem_wstrb_d = st_strb;
            if (mis_trap) begin
                state_d    = ST_DONE;
                misalign_d = 1'b1;
                ld_data_d  = 32'h0;
            end else begin
                state_d   = ST_REQ;
                mem_req_d = 1'b1;
                tmr_d     = TMR_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            size_q      <= 2'b00;
            sgn_q       <= 1'b0;
            lane_q      <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'h0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= 32'h0;
            bus_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            lane_q      <= lane_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            ld_valid_q  <= ld_valid_d;
            ld_data_q   <= ld_data_d;
            bus_err_q   <= bus_err_d;
            misalign_q  <= misalign_d;
        end
    end

    assign stall         = accept | (state_q == ST_REQ);
    assign ld_valid      = ld_valid_q;
    assign ld_data       = ld_data_q;
    assign bus_err       = bus_err_q;
    assign misalign      = misalign_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Self-checking bench for load_store_unit. Expected load results are queued
//   when an access is issued and compared when ld_valid pulses.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_rd, ex_wr, ex_signed;
    logic [31:0] ex_addr, ex_wdata;
    logic [1:0]  ex_size;
    logic        stall, ld_valid, bus_err, misalign;
    logic [31:0] ld_data;

    load_store_unit_if mif ();

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .ex_rd     (ex_rd),
        .ex_wr     (ex_wr),
        .ex_addr   (ex_addr),
        .ex_wdata  (ex_wdata),
        .ex_size   (ex_size),
        .ex_signed (ex_signed),
        .stall     (stall),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .bus_err   (bus_err),
        .misalign  (misalign),
        .mem       (mif)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    // Results of the last do_access call.
    int          stall_cnt, req_cyc;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_strb;
    logic        a_we, a_stable;

    // Scoreboard: every ld_valid pulse must match the oldest queued load.
    always @(negedge clk) begin
        if (ld_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL ld_unexpected got ld_data=%h exp no ld_valid", ld_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (ld_data !== mon_e) begin
                    n_err++;
                    $display("FAIL ld_data got %h exp %h", ld_data, mon_e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_ld(logic [31:0] rd, logic [1:0] a,
                                             logic [1:0] sz, logic sg);
        logic [31:0] sh;
        case (sz)
            2'b00: begin
                sh = rd >> (int'(a) * 8);
                return sg ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
            end
            2'b01: begin
                sh = a[1] ? (rd >> 16) : rd;
                return sg ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
            end
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(logic [1:0] a, logic [1:0] sz);
        logic [3:0] s;
        s = 4'h0;
        case (sz)
            2'b00:   s[a] = 1'b1;
            2'b01:   s = a[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one access starting now (1ns after an edge) and acks on REQ
    // cycle ack_cyc (0 = never). Returns at the first cycle after REQ.
    task automatic do_access(input logic we, input logic rd, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [1:0] size,
                             input logic sgn, input int ack_cyc, input logic [31:0] rdata);
        ex_valid  = 1'b1;
        ex_wr     = we;
        ex_rd     = rd;
        ex_addr   = addr;
        ex_wdata  = wd;
        ex_size   = size;
        ex_signed = sgn;
        stall_cnt = 0;
        req_cyc   = 0;
        a_stable  = 1'b1;
        #1;
        if (stall === 1'b1) stall_cnt++;
        step();
        ex_valid = 1'b0;
        ex_wr    = 1'b0;
        ex_rd    = 1'b0;
        a_addr   = mif.mem_addr;
        a_wdata  = mif.mem_wdata;
        a_strb   = mif.mem_wstrb;
        a_we     = mif.mem_we;
        while (mif.mem_req === 1'b1 && req_cyc < 40) begin
            req_cyc++;
            if (mif.mem_addr !== a_addr || mif.mem_wdata !== a_wdata ||
                mif.mem_wstrb !== a_strb || mif.mem_we !== a_we)
                a_stable = 1'b0;
            if (req_cyc == ack_cyc) begin
                mif.mem_ack   = 1'b1;
                mif.mem_rdata = rdata;
            end
            #1;
            if (stall === 1'b1) stall_cnt++;
            step();
            mif.mem_ack   = 1'b0;
            mif.mem_rdata = $urandom;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ex_valid = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0; ex_signed = 1'b0;
        ex_addr = 32'h0; ex_wdata = 32'h0; ex_size = 2'b00;
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
        repeat (3) step();
        rst = 1'b0;
        n_cmp++;
        if ({stall, ld_valid, bus_err, misalign, mif.mem_req, mif.mem_we, mif.mem_wstrb} !== 10'h0) begin
            n_err++;
            $display("FAIL reset_ctrl got %b exp 0", {stall, ld_valid, bus_err, misalign,
                     mif.mem_req, mif.mem_we, mif.mem_wstrb});
        end
        n_cmp++;
        if ({ld_data, mif.mem_addr, mif.mem_wdata} !== 96'h0) begin
            n_err++;
            $display("FAIL reset_data got %h %h %h exp 0", ld_data, mif.mem_addr, mif.mem_wdata);
        end
        step();
        n_cmp++;
        if (mif.mem_req !== 1'b0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle got req=%b stall=%b exp 0 0", mif.mem_req, stall);
        end
    endtask

    task automatic test_word_store();
        do_access(1'b1, 1'b0, 32'h104, 32'hDEADBEEF, 2'b10, 1'b0, 3, 32'h0);
        n_cmp++;
        if (a_addr !== 32'h104 || a_strb !== 4'hF || a_wdata !== 32'hDEADBEEF || a_we !== 1'b1) begin
            n_err++;
            $display("FAIL word_store_bus got addr=%h strb=%b wdata=%h we=%b exp 104 1111 deadbeef 1",
                     a_addr, a_strb, a_wdata, a_we);
        end
        n_cmp++;
        if (stall_cnt !== 4 || req_cyc !== 3) begin
            n_err++;
            $display("FAIL word_store_stall got stall=%0d req=%0d exp 4 3", stall_cnt, req_cyc);
        end
        n_cmp++;
        if (a_stable !== 1'b1) begin
            n_err++;
            $display("FAIL word_store_hold got stable=%b exp 1", a_stable);
        end
        n_cmp++;
        if (stall !== 1'b0 || ld_valid !== 1'b0 || bus_err !== 1'b0) begin
            n_err++;
            $display("FAIL word_store_done got stall=%b ldv=%b berr=%b exp 0 0 0",
                     stall, ld_valid, bus_err);
        end
        step();
    endtask

    task automatic test_byte_load_signed();
        exp_q.push_back(32'hFFFFFF80);
        do_access(1'b0, 1'b1, 32'h103, 32'h0, 2'b00, 1'b1, 2, 32'h80FF_0000);
        n_cmp++;
        if (a_addr !== 32'h100 || a_strb !== 4'b1000 || a_we !== 1'b0) begin
            n_err++;
            $display("FAIL byte_load_bus got addr=%h strb=%b we=%b exp 100 1000 0", a_addr, a_strb, a_we);
        end
        n_cmp++;
        if (ld_valid !== 1'b1 || stall_cnt !== 3) begin
            n_err++;
            $display("FAIL byte_load_done got ldv=%b stall=%0d exp 1 3", ld_valid, stall_cnt);
        end
        step();
    endtask

    task automatic test_half_load_latency();
        exp_q.push_back(32'h0000_8001);
        do_access(1'b0, 1'b1, 32'h102, 32'h0, 2'b01, 1'b0, 1, 32'h8001_1234);
        n_cmp++;
        if (req_cyc !== 1 || ld_valid !== 1'b1 || ld_data !== 32'h0000_8001) begin
            n_err++;
            $display("FAIL half_load_n2 got req=%0d ldv=%b data=%h exp 1 1 00008001",
                     req_cyc, ld_valid, ld_data);
        end
        step();
        n_cmp++;
        if (ld_valid !== 1'b0) begin
            n_err++;
            $display("FAIL half_load_pulse got ldv=%b exp 0", ld_valid);
        end
    endtask

    task automatic test_lanes();
        logic [31:0] d, a;
        logic [1:0]  sz;
        for (int i = 0; i < 7; i++) begin
            d  = $urandom;
            a  = 32'h2000 + 32'(i);
            sz = (i < 4) ? 2'b00 : ((i < 6) ? 2'b01 : 2'b10);
            if (i == 5) a = 32'h2002;
            // i==6 sets both rd and wr: the write must win.
            do_access(1'b1, (i == 6), a, d, sz, 1'b0, 1 + (i % 3), 32'h0);
            n_cmp++;
            if (a_strb !== model_strb(a[1:0], sz) || a_we !== 1'b1 ||
                a_wdata !== (sz == 2'b00 ? {4{d[7:0]}} : (sz == 2'b01 ? {2{d[15:0]}} : d))) begin
                n_err++;
                $display("FAIL store_lane%0d got strb=%b we=%b wdata=%h exp strb=%b",
                         i, a_strb, a_we, a_wdata, model_strb(a[1:0], sz));
            end
        end
        for (int i = 0; i < 8; i++) begin
            d  = $urandom;
            sz = (i < 4) ? 2'b00 : 2'b01;
            a  = (i < 4) ? 32'h3000 + 32'(i) : 32'h3000 + 32'((i % 2) * 2);
            exp_q.push_back(model_ld(d, a[1:0], sz, i[0] ^ i[2]));
            do_access(1'b0, 1'b1, a, 32'h0, sz, i[0] ^ i[2], 1 + (i % 2), d);
        end
        step();
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(32'h0000_00A5);
        do_access(1'b0, 1'b1, 32'h500, 32'h0, 2'b00, 1'b0, 1, 32'h1234_56A5);
        exp_q.push_back(32'hFFFF_9ABC);
        do_access(1'b0, 1'b1, 32'h502, 32'h0, 2'b01, 1'b1, 2, 32'h9ABC_0000);
        n_cmp++;
        if (stall_cnt !== 3) begin
            n_err++;
            $display("FAIL b2b_load_stall got %0d exp 3", stall_cnt);
        end
        do_access(1'b1, 1'b0, 32'h508, 32'h0BAD_F00D, 2'b10, 1'b0, 1, 32'h0);
        n_cmp++;
        if (stall_cnt !== 2 || a_addr !== 32'h508) begin
            n_err++;
            $display("FAIL b2b_store got stall=%0d addr=%h exp 2 508", stall_cnt, a_addr);
        end
        step();
    endtask

    task automatic test_timeout();
        exp_q.push_back(32'hA5A5_A5A5);
        do_access(1'b0, 1'b1, 32'h600, 32'h0, 2'b10, 1'b0, 1, 32'hA5A5_A5A5);
        step();
        do_access(1'b0, 1'b1, 32'h604, 32'h0, 2'b10, 1'b0, 0, 32'h0);
        n_cmp++;
        if (req_cyc !== 16 || stall_cnt !== 17) begin
            n_err++;
            $display("FAIL timeout_len got req=%0d stall=%0d exp 16 17", req_cyc, stall_cnt);
        end
        n_cmp++;
        if (bus_err !== 1'b1 || ld_valid !== 1'b0 || ld_data !== 32'h0) begin
            n_err++;
            $display("FAIL timeout_done got berr=%b ldv=%b data=%h exp 1 0 0", bus_err, ld_valid, ld_data);
        end
        step();
        n_cmp++;
        if (bus_err !== 1'b0 || mif.mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_after got berr=%b req=%b exp 0 0", bus_err, mif.mem_req);
        end
        exp_q.push_back(32'h1357_9BDF);
        do_access(1'b0, 1'b1, 32'h608, 32'h0, 2'b10, 1'b0, 16, 32'h1357_9BDF);
        n_cmp++;
        if (req_cyc !== 16 || bus_err !== 1'b0 || ld_valid !== 1'b1) begin
            n_err++;
            $display("FAIL ack_at_limit got req=%0d berr=%b ldv=%b exp 16 0 1", req_cyc, bus_err, ld_valid);
        end
        step();
    endtask

    task automatic test_misalign();
        exp_q.push_back(32'h7777_7777);
        do_access(1'b0, 1'b1, 32'h700, 32'h0, 2'b10, 1'b0, 1, 32'h7777_7777);
        step();
`ifdef MISALIGN_TRAP_EN
        do_access(1'b0, 1'b1, 32'h102, 32'h0, 2'b10, 1'b0, 1, 32'h0);
        n_cmp++;
        if (req_cyc !== 0 || stall_cnt !== 1 || misalign !== 1'b1 || ld_data !== 32'h0) begin
            n_err++;
            $display("FAIL misalign_trap got req=%0d stall=%0d mis=%b data=%h exp 0 1 1 0",
                     req_cyc, stall_cnt, misalign, ld_data);
        end
        step();
        n_cmp++;
        if (misalign !== 1'b0 || mif.mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_after got mis=%b req=%b exp 0 0", misalign, mif.mem_req);
        end
`else
        exp_q.push_back(32'hCAFE_0102);
        do_access(1'b0, 1'b1, 32'h102, 32'h0, 2'b10, 1'b0, 1, 32'hCAFE_0102);
        n_cmp++;
        if (a_addr !== 32'h100 || a_strb !== 4'hF || misalign !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_word got addr=%h strb=%b mis=%b exp 100 1111 0", a_addr, a_strb, misalign);
        end
        exp_q.push_back(32'h0000_CAFE);
        do_access(1'b0, 1'b1, 32'h103, 32'h0, 2'b01, 1'b0, 1, 32'hCAFE_0102);
        n_cmp++;
        if (a_strb !== 4'b1100 || misalign !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_half got strb=%b mis=%b exp 1100 0", a_strb, misalign);
        end
        step();
`endif
    endtask

    task automatic test_rst_in_req();
        logic quiet;
        ex_valid = 1'b1; ex_rd = 1'b1; ex_wr = 1'b0;
        ex_addr = 32'h400; ex_size = 2'b10; ex_signed = 1'b0;
        step();
        ex_valid = 1'b0; ex_rd = 1'b0;
        n_cmp++;
        if (mif.mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL rst_req_entry got req=%b exp 1", mif.mem_req);
        end
        step();
        rst = 1'b1;
        step();
        n_cmp++;
        if (mif.mem_req !== 1'b0 || stall !== 1'b0 || ld_valid !== 1'b0 || bus_err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_in_req got req=%b stall=%b ldv=%b berr=%b exp 0 0 0 0",
                     mif.mem_req, stall, ld_valid, bus_err);
        end
        rst = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus_err !== 1'b0 || mif.mem_req !== 1'b0 || ld_valid !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_err++;
            $display("FAIL rst_abandon got quiet=%b exp 1", quiet);
        end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_load_signed();
        test_half_load_latency();
        test_lanes();
        test_back_to_back();
        test_timeout();
        test_misalign();
        test_rst_in_req();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_loads got %0d exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
